// File: rtl/writeback_regfile.sv
// ----------------------------------------------------------------------------
// writeback_regfile
//
// Writeback stage and architectural register file at the consumer end of the
// MEM/WB pipeline register.
//
// Writeback value
//   The value written back is either the load data or the ALU result.
//   It is committed to R0..R14.
//   A writeback that targets R15 (the PC) does not touch the register file.
//   Instead it raises a PC redirect to the fetch logic.
//
// Read ports
//   There are three combinational decode read ports.
//   Each port has a same-cycle write-through bypass.
//   Reads of R15 always return the live PC.
//
// Forwarding
//   The writeback destination, enable and value are exported for the
//   forwarding unit.
//
// Parameters
//   DATA_W  register / data width
//   NREG    architectural registers including R15 (R15 = PC, not stored)
//   CNT_W   width of the committed-writeback counter (wraps silently)
//
// Ports
//   CLK            in   rising-edge clock
//   CLR            in   asynchronous active-low reset
//   Load_In        in   1 = writeback Data_Mem_In, 0 = writeback Alu_In
//   rf_In          in   register write enable from MEM/WB
//   Data_Mem_In    in   load data
//   Alu_In         in   ALU result
//   Rd_In          in   destination register
//   PC_In          in   current PC, returned on R15 reads
//   RA/RB/RC_Addr_In in read port addresses
//   RA/RB/RC_Out   out  read port data
//   Wb_Data_Out    out  selected writeback value
//   Wb_Rd_Out      out  copy of Rd_In
//   Wb_En_Out      out  copy of rf_In
//   PC_Load_Out    out  writeback targets R15
//   PC_Target_Out  out  redirect target (0 when PC_Load_Out = 0)
//   Wb_Count_Out   out  committed writebacks since reset
// ----------------------------------------------------------------------------
module writeback_regfile #(
   parameter int DATA_W = 32,
   parameter int NREG   = 16,
   parameter int CNT_W  = 32
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              Load_In,
   input  logic              rf_In,
   input  logic [DATA_W-1:0] Data_Mem_In,
   input  logic [DATA_W-1:0] Alu_In,
   input  logic [3:0]        Rd_In,
   input  logic [DATA_W-1:0] PC_In,
   input  logic [3:0]        RA_Addr_In,
   input  logic [3:0]        RB_Addr_In,
   input  logic [3:0]        RC_Addr_In,
   output logic [DATA_W-1:0] RA_Out,
   output logic [DATA_W-1:0] RB_Out,
   output logic [DATA_W-1:0] RC_Out,
   output logic [DATA_W-1:0] Wb_Data_Out,
   output logic [3:0]        Wb_Rd_Out,
   output logic              Wb_En_Out,
   output logic              PC_Load_Out,
   output logic [DATA_W-1:0] PC_Target_Out,
   output logic [CNT_W-1:0]  Wb_Count_Out
);

   localparam logic [3:0] PC_IDX = 4'(NREG - 1);

   // Slot PC_IDX exists only so a 4-bit address indexes the array without
   // range issues; it is never written and is masked by the PC read path.
   logic [DATA_W-1:0] r_regs [NREG];
   logic [CNT_W-1:0]  r_wb_count;

   logic [DATA_W-1:0] w_wb_data;
   logic              w_pc_hit;
   logic              w_rf_write;

   // Read priority: PC first, then write-through bypass, then stored value.
   function automatic logic [DATA_W-1:0] f_read_port(
      input logic [3:0]        addr,
      input logic [DATA_W-1:0] stored,
      input logic [DATA_W-1:0] pc,
      input logic              wb_en,
      input logic [3:0]        wb_rd,
      input logic [DATA_W-1:0] wb_data
   );
      if (addr == PC_IDX)
         return pc;
      else if (wb_en && (wb_rd == addr))
         return wb_data;
      else
         return stored;
   endfunction

   // Writeback select and write decode.
   assign w_wb_data  = Load_In ? Data_Mem_In : Alu_In;
   assign w_pc_hit   = rf_In && (Rd_In == PC_IDX);
   assign w_rf_write = rf_In && (Rd_In != PC_IDX);

   // Forwarding pass-through.
   assign Wb_Data_Out = w_wb_data;
   assign Wb_Rd_Out   = Rd_In;
   assign Wb_En_Out   = rf_In;

   // PC redirect: target is forced to zero when no redirect, keeping the
   // output clean for the fetch mux.
   assign PC_Load_Out   = w_pc_hit;
   assign PC_Target_Out = w_pc_hit ? w_wb_data : '0;

   // Register file commit.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         for (int i = 0; i < NREG; i++)
            r_regs[i] <= '0;
      end else if (w_rf_write) begin
         r_regs[Rd_In] <= w_wb_data;
      end
   end

   // Committed-writeback counter, R15 writebacks included; wraps silently.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR)
         r_wb_count <= '0;
      else if (rf_In)
         r_wb_count <= r_wb_count + 1'b1;
   end

   assign Wb_Count_Out = r_wb_count;

   // Read ports.
   always_comb begin
      RA_Out = f_read_port(RA_Addr_In, r_regs[RA_Addr_In], PC_In,
                           rf_In, Rd_In, w_wb_data);
      RB_Out = f_read_port(RB_Addr_In, r_regs[RB_Addr_In], PC_In,
                           rf_In, Rd_In, w_wb_data);
      RC_Out = f_read_port(RC_Addr_In, r_regs[RC_Addr_In], PC_In,
                           rf_In, Rd_In, w_wb_data);
   end

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;

   logic        CLK = 1'b0;
   logic        CLR = 1'b0;
   logic        Load_In = 1'b0;
   logic        rf_In = 1'b0;
   logic [31:0] Data_Mem_In = '0;
   logic [31:0] Alu_In = '0;
   logic [3:0]  Rd_In = '0;
   logic [31:0] PC_In = '0;
   logic [3:0]  RA_Addr_In = '0;
   logic [3:0]  RB_Addr_In = '0;
   logic [3:0]  RC_Addr_In = '0;

   logic [31:0] RA_Out, RB_Out, RC_Out, Wb_Data_Out, PC_Target_Out, Wb_Count_Out;
   logic [3:0]  Wb_Rd_Out;
   logic        Wb_En_Out, PC_Load_Out;

   // Narrow-counter instance for the wrap check; shares all inputs.
   logic [31:0] s_RA, s_RB, s_RC, s_WbData, s_PcTgt;
   logic [3:0]  s_WbRd, s_Cnt;
   logic        s_WbEn, s_PcLd;

   int errors = 0;
   int checks = 0;

   // Reference state.
   logic [31:0] m_regs [16];
   logic [31:0] m_count;

   always #5 CLK = ~CLK;

   writeback_regfile #(.DATA_W(32), .NREG(16), .CNT_W(32)) dut (
      .CLK(CLK), .CLR(CLR), .Load_In(Load_In), .rf_In(rf_In),
      .Data_Mem_In(Data_Mem_In), .Alu_In(Alu_In), .Rd_In(Rd_In), .PC_In(PC_In),
      .RA_Addr_In(RA_Addr_In), .RB_Addr_In(RB_Addr_In), .RC_Addr_In(RC_Addr_In),
      .RA_Out(RA_Out), .RB_Out(RB_Out), .RC_Out(RC_Out),
      .Wb_Data_Out(Wb_Data_Out), .Wb_Rd_Out(Wb_Rd_Out), .Wb_En_Out(Wb_En_Out),
      .PC_Load_Out(PC_Load_Out), .PC_Target_Out(PC_Target_Out),
      .Wb_Count_Out(Wb_Count_Out)
   );

   writeback_regfile #(.DATA_W(32), .NREG(16), .CNT_W(4)) dut4 (
      .CLK(CLK), .CLR(CLR), .Load_In(Load_In), .rf_In(rf_In),
      .Data_Mem_In(Data_Mem_In), .Alu_In(Alu_In), .Rd_In(Rd_In), .PC_In(PC_In),
      .RA_Addr_In(RA_Addr_In), .RB_Addr_In(RB_Addr_In), .RC_Addr_In(RC_Addr_In),
      .RA_Out(s_RA), .RB_Out(s_RB), .RC_Out(s_RC),
      .Wb_Data_Out(s_WbData), .Wb_Rd_Out(s_WbRd), .Wb_En_Out(s_WbEn),
      .PC_Load_Out(s_PcLd), .PC_Target_Out(s_PcTgt),
      .Wb_Count_Out(s_Cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_wb();
      return Load_In ? Data_Mem_In : Alu_In;
   endfunction

   // Read rule: PC, then bypass, then stored value.
   function automatic logic [31:0] m_read(input logic [3:0] a);
      if (a == 4'd15)
         return PC_In;
      if (rf_In && Rd_In == a)
         return m_wb();
      return m_regs[a];
   endfunction

   task automatic check_comb(input string tag);
      logic pcl;
      pcl = rf_In && (Rd_In == 4'd15);
      chk({tag, ":RA"}, RA_Out, m_read(RA_Addr_In));
      chk({tag, ":RB"}, RB_Out, m_read(RB_Addr_In));
      chk({tag, ":RC"}, RC_Out, m_read(RC_Addr_In));
      chk({tag, ":wbdata"}, Wb_Data_Out, m_wb());
      chk({tag, ":wbrd"}, {28'd0, Wb_Rd_Out}, {28'd0, Rd_In});
      chk({tag, ":wben"}, {31'd0, Wb_En_Out}, {31'd0, rf_In});
      chk({tag, ":pcload"}, {31'd0, PC_Load_Out}, {31'd0, pcl});
      chk({tag, ":pctgt"}, PC_Target_Out, pcl ? m_wb() : 32'd0);
      chk({tag, ":count"}, Wb_Count_Out, m_count);
      chk({tag, ":count4"}, {28'd0, s_Cnt}, {28'd0, m_count[3:0]});
      chk({tag, ":RA4"}, s_RA, m_read(RA_Addr_In));
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic cycle(input string tag);
      #1 check_comb(tag);
      @(posedge CLK);
      if (CLR && rf_In) begin
         if (Rd_In != 4'd15)
            m_regs[Rd_In] = m_wb();
         m_count = m_count + 1;
      end
      @(negedge CLK);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++)
         m_regs[i] = '0;
      m_count = '0;
   endtask

   task automatic drive(input logic rf, input logic ld, input logic [3:0] rd,
                        input logic [31:0] alu, input logic [31:0] mem);
      rf_In = rf; Load_In = ld; Rd_In = rd; Alu_In = alu; Data_Mem_In = mem;
   endtask

   task automatic addrs(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      RA_Addr_In = a; RB_Addr_In = b; RC_Addr_In = c;
   endtask

   // Asynchronous reset pulse between edges, with a write presented meanwhile.
   task automatic reset_pulse(input string tag, input logic [3:0] rd,
                              input logic [31:0] val);
      #2 CLR = 1'b0;
      #1 model_clear();
      check_comb({tag, ":async"});
      @(negedge CLK);
      drive(1'b1, 1'b0, rd, val, 32'h0);
      addrs(rd, rd, 4'd15);
      cycle({tag, ":held"});
      CLR = 1'b1;
      drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
   endtask

   initial begin
      model_clear();
      // Reset then read.
      repeat (2) @(negedge CLK);
      addrs(4'd0, 4'd7, 4'd14);
      #1 check_comb("rst_low");
      @(negedge CLK);
      CLR = 1'b1;
      cycle("rst_read");

      // ALU vs load select.
      drive(1'b1, 1'b0, 4'd3, 32'h0000_00AA, 32'h0);
      addrs(4'd3, 4'd0, 4'd1);
      cycle("alu_wr");
      drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
      addrs(4'd3, 4'd3, 4'd2);
      #1 chk("alu_r3", RA_Out, 32'h0000_00AA);
      drive(1'b1, 1'b1, 4'd3, 32'h0, 32'hDEAD_BEEF);
      cycle("load_wr");
      drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
      #1 chk("load_r3", RA_Out, 32'hDEAD_BEEF);
      chk("count2", Wb_Count_Out, 32'd2);

      // Bypass on all ports, then old value without enable.
      drive(1'b1, 1'b0, 4'd5, 32'h0000_1234, 32'h0);
      addrs(4'd5, 4'd5, 4'd5);
      #1 chk("byp_RA", RA_Out, 32'h1234);
      chk("byp_RC", RC_Out, 32'h1234);
      cycle("byp");
      drive(1'b0, 1'b0, 4'd5, 32'h0000_9999, 32'h0);
      cycle("nobyp");

      // R15 redirect.
      PC_In = 32'h100;
      drive(1'b1, 1'b0, 4'd15, 32'h200, 32'h0);
      addrs(4'd15, 4'd3, 4'd5);
      #1 chk("r15_pcload", {31'd0, PC_Load_Out}, 32'd1);
      chk("r15_tgt", PC_Target_Out, 32'h200);
      chk("r15_RA", RA_Out, 32'h100);
      cycle("r15");
      drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
      cycle("r15_after");

      // Bubble.
      addrs(4'd3, 4'd5, 4'd0);
      cycle("bubble");

      // Async reset mid-operation.
      drive(1'b1, 1'b0, 4'd2, 32'h55, 32'h0);
      addrs(4'd2, 4'd3, 4'd5);
      cycle("r2_wr");
      drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
      reset_pulse("midrst", 4'd2, 32'h77);
      addrs(4'd2, 4'd3, 4'd5);
      cycle("post_rst");

      // Counter wrap on the narrow instance: 16 writes from zero.
      reset_pulse("wraprst", 4'd1, 32'h1);
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, i[0], 4'(i), 32'(i * 3), 32'(i * 5));
         addrs(4'(i), 4'd15, 4'd0);
         cycle("wrap");
      end
      drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
      #1 chk("wrap4", {28'd0, s_Cnt}, 32'd0);
      chk("wrap32", Wb_Count_Out, 32'd16);

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         drive($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom_range(0, 15)),
               $urandom, $urandom);
         PC_In = $urandom;
         addrs(4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0) ? Rd_In
               : 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 49) == 0)
            reset_pulse("rnd_rst", Rd_In, Alu_In);
         else
            cycle("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: owns the writeback stage and the architectural register file.
- Selects the writeback value: load data or ALU result.
- Commits it to R0–R14, or redirects the PC when the destination is R15.
- Serves three decode-stage read ports with same-cycle write bypass, and exports writeback info to the forwarding unit.

Parameters:
- DATA_W, 32, register/data width
- NREG, 16, architectural registers (R15 = PC, not stored)
- CNT_W, 32, width of committed-write counter

Ports:
- CLK  input  1  clock, rising edge
- CLR  input  1  asynchronous active-low reset
- Load_In  input  1  from MEM/WB: 1 = writeback value is Data_Mem_In, 0 = Alu_In
- rf_In  input  1  from MEM/WB: register write enable
- Data_Mem_In  input  DATA_W  from MEM/WB: load data
- Alu_In  input  DATA_W  from MEM/WB: ALU result
- Rd_In  input  4  from MEM/WB: destination register
- PC_In  input  DATA_W  current PC value returned on R15 reads
- RA_Addr_In  input  4  read port A address (Rn)
- RB_Addr_In  input  4  read port B address (Rm)
- RC_Addr_In  input  4  read port C address (Rd for stores)
- RA_Out  output  DATA_W  read port A data
- RB_Out  output  DATA_W  read port B data
- RC_Out  output  DATA_W  read port C data
- Wb_Data_Out  output  DATA_W  selected writeback value (forwarding source)
- Wb_Rd_Out  output  4  equals Rd_In
- Wb_En_Out  output  1  equals rf_In
- PC_Load_Out  output  1  writeback targets R15
- PC_Target_Out  output  DATA_W  new PC when PC_Load_Out=1
- Wb_Count_Out  output  CNT_W  committed writebacks since reset

Behaviour:
- Wb_Data = Load_In ? Data_Mem_In : Alu_In (combinational); Wb_Data_Out = Wb_Data.
- Register write:
  - at posedge CLK with CLR=1, rf_In=1 and Rd_In≠15: reg[Rd_In] ← Wb_Data.
  - Exactly one register written per cycle; all others hold.
- R15 writeback:
  - rf_In=1 and Rd_In=15 → PC_Load_Out=1 and PC_Target_Out=Wb_Data, combinational in the same cycle; no register-file write.
  - Otherwise PC_Load_Out=0 and PC_Target_Out=0.
- Reads are combinational, with priority per port:
  - addr=15 → PC_In (even if R15 is being written that cycle);
  - else rf_In=1 and Rd_In=addr → Wb_Data (write-through bypass, zero latency);
  - else reg[addr].
- All three ports may hit the same address or the bypass simultaneously; each resolves independently.
- Wb_Count_Out:
  - increments by 1 at posedge CLK when rf_In=1, including R15 writes.
  - Wraps from 2^CNT_W−1 to 0 with no flag.
- Reset:
  - CLR=0 asynchronously clears R0–R14 and Wb_Count_Out to 0, independent of CLK.
  - While CLR=0, no write occurs even if rf_In=1.
  - Reads return 0 for R0–R14 unless bypassed; bypass remains combinational during reset.
  - On the first rising CLK after CLR returns to 1, writes resume normally.
  - Reset asserted mid-stream discards any pending write.
- Pass-through outputs (Wb_Rd_Out, Wb_En_Out, Wb_Data_Out) are combinational and carry no reset state.
- A clean MEM/WB bubble (all zero) yields no write, no count, and PC_Load_Out=0.
- X-free requirement: all outputs are defined for every input combination once CLR has been applied.

Test Plan:
- Reset then read: CLR=0, release, RA/RB/RC=0,7,14 with rf_In=0 → all read 0; Wb_Count_Out=0.
- ALU vs load select:
  - rf_In=1, Load_In=0, Alu_In=0x0000_00AA, Rd_In=3 → after edge, R3 reads 0xAA.
  - Then Load_In=1, Data_Mem_In=0xDEAD_BEEF, Rd_In=3 → R3 reads 0xDEADBEEF; count=2.
- Bypass:
  - rf_In=1, Rd_In=5, Alu_In=0x1234 with RA=RB=RC=5 before the edge → all ports 0x1234 the same cycle.
  - With rf_In=0 → old R5 value.
- R15:
  - PC_In=0x100, rf_In=1, Rd_In=15, Alu_In=0x200 → PC_Load_Out=1, PC_Target_Out=0x200, RA(15)=0x100.
  - No register changes; count increments.
- Async reset mid-operation: write R2=0x55, then pull CLR low between edges → R2 reads 0 immediately; write presented during reset is not committed.
- Counter wrap: CNT_W=4, 16 consecutive writes → Wb_Count_Out returns to 0.
